mem_port_arbiter: RTL and testbench

Arbitrates the single-port system RAM between two requesters: the CPU memory interface (MAR/MDR path driven by the control unit's Read/Write strobes) and the debug/program loader port. Each request completes in three cycles: accept, one-cycle RAM strobe, then a response with a one-cycle acknowledge. The block sits between the CPU datapath and the RAM, so the loader can preload or inspect memory while the processor runs or is halted.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: state encoding, port IDs and default widths.

package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      COMPLETE = 2'd2
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   localparam int unsigned ADDR_W_DEF = 9;
   localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between the CPU memory interface and the debug/program loader.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the CPU always wins ties.

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              CPU_Req,
   input  logic              CPU_Write,
   input  logic [ADDR_W-1:0] CPU_Addr,
   input  logic [DATA_W-1:0] CPU_WData,
   output logic              CPU_Ack,
   output logic [DATA_W-1:0] CPU_RData,
   input  logic              DBG_Req,
   input  logic              DBG_Write,
   input  logic [ADDR_W-1:0] DBG_Addr,
   input  logic [DATA_W-1:0] DBG_WData,
   output logic              DBG_Ack,
   output logic [DATA_W-1:0] DBG_RData,
   output logic              Mem_Read,
   output logic              Mem_Write,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_WData,
   input  logic [DATA_W-1:0] Mem_RData,
   output logic              Busy,
   output logic              Grant_DBG
);

   arb_state_e        state_q, state_d;
   logic              grant_q, grant_d;
   logic              lat_write_q, lat_write_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              any_req;
   logic              winner;

   assign any_req = CPU_Req | DBG_Req;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // Ties go to the port not granted last; reset to DBG so the first tie favours the CPU.
   always_comb begin
      if (CPU_Req && DBG_Req) begin
         winner = ~last_q;
      end else begin
         winner = DBG_Req ? PORT_DBG : PORT_CPU;
      end
      last_d = (state_q == IDLE && any_req) ? winner : last_q;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         last_q <= PORT_DBG;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      winner = CPU_Req ? PORT_CPU : PORT_DBG;
   end
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      lat_write_d = lat_write_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d     = winner;
               lat_write_d = (winner == PORT_DBG) ? DBG_Write : CPU_Write;
               lat_addr_d  = (winner == PORT_DBG) ? DBG_Addr  : CPU_Addr;
               lat_wdata_d = (winner == PORT_DBG) ? DBG_WData : CPU_WData;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            state_d = COMPLETE;
         end
         COMPLETE: begin
            if (!lat_write_q) begin
               if (grant_q == PORT_DBG) begin
                  dbg_rdata_d = Mem_RData;
               end else begin
                  cpu_rdata_d = Mem_RData;
               end
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         grant_q     <= PORT_CPU;
         lat_write_q <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lat_write_q <= lat_write_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign Busy      = (state_q != IDLE);
   assign Grant_DBG = grant_q;
   assign Mem_Read  = (state_q == ISSUE) && !lat_write_q;
   assign Mem_Write = (state_q == ISSUE) &&  lat_write_q;
   assign Mem_Addr  = lat_addr_q;
   assign Mem_WData = lat_wdata_q;
   assign CPU_Ack   = (state_q == COMPLETE) && (grant_q == PORT_CPU);
   assign DBG_Ack   = (state_q == COMPLETE) && (grant_q == PORT_DBG);

   // RAM data arrives during the Ack cycle; forward it so RData is valid alongside Ack.
   assign CPU_RData = (CPU_Ack && !lat_write_q) ? Mem_RData : cpu_rdata_q;
   assign DBG_RData = (DBG_Ack && !lat_write_q) ? Mem_RData : dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard on Acks, corner sequences.

module tb_mem_port_arbiter;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 32;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          CPU_Req = 1'b0, CPU_Write = 1'b0;
   logic [AW-1:0] CPU_Addr = '0;
   logic [DW-1:0] CPU_WData = '0;
   logic          CPU_Ack;
   logic [DW-1:0] CPU_RData;
   logic          DBG_Req = 1'b0, DBG_Write = 1'b0;
   logic [AW-1:0] DBG_Addr = '0;
   logic [DW-1:0] DBG_WData = '0;
   logic          DBG_Ack;
   logic [DW-1:0] DBG_RData;
   logic          Mem_Read, Mem_Write;
   logic [AW-1:0] Mem_Addr;
   logic [DW-1:0] Mem_WData;
   logic [DW-1:0] Mem_RData = '0;
   logic          Busy, Grant_DBG;

   mem_port_arbiter dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .CPU_Req  (CPU_Req),
      .CPU_Write(CPU_Write),
      .CPU_Addr (CPU_Addr),
      .CPU_WData(CPU_WData),
      .CPU_Ack  (CPU_Ack),
      .CPU_RData(CPU_RData),
      .DBG_Req  (DBG_Req),
      .DBG_Write(DBG_Write),
      .DBG_Addr (DBG_Addr),
      .DBG_WData(DBG_WData),
      .DBG_Ack  (DBG_Ack),
      .DBG_RData(DBG_RData),
      .Mem_Read (Mem_Read),
      .Mem_Write(Mem_Write),
      .Mem_Addr (Mem_Addr),
      .Mem_WData(Mem_WData),
      .Mem_RData(Mem_RData),
      .Busy     (Busy),
      .Grant_DBG(Grant_DBG)
   );

   always #5 Clock = ~Clock;

   // Synchronous RAM model: read data valid the cycle after Mem_Read.
   logic [DW-1:0] ram [512];
   always @(posedge Clock) begin
      if (Mem_Write) ram[Mem_Addr] <= Mem_WData;
      if (Mem_Read)  Mem_RData <= ram[Mem_Addr];
   end

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic          port;
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q [$];
   int   ack_t [$];
   exp_t mon_e;

   // Scoreboard: every Ack must match the oldest outstanding expectation.
   always @(negedge Clock) begin
      if (!Reset) begin
         check("strobe exclusive", {31'd0, Mem_Read & Mem_Write}, 32'd0);
         if (CPU_Ack || DBG_Ack) begin
            check("single ack", {31'd0, CPU_Ack & DBG_Ack}, 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected ack: cpu=%0b dbg=%0b, expected no ack (t=%0t)",
                        CPU_Ack, DBG_Ack, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("ack port", {31'd0, DBG_Ack}, {31'd0, mon_e.port});
               check("grant during ack", {31'd0, Grant_DBG}, {31'd0, mon_e.port});
               if (!mon_e.write)
                  check("rdata with ack", DBG_Ack ? DBG_RData : CPU_RData, mon_e.data);
            end
            ack_t.push_back(cyc);
         end
      end
   end

   task automatic push_exp(input logic port, input logic write, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
      exp_t e;
      e.port = port; e.write = write; e.addr = addr; e.data = data;
      exp_q.push_back(e);
   endtask

   // One isolated transaction; called and returns at posedge+1 with the DUT in IDLE.
   task automatic run_single(input logic port, input logic write, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
      push_exp(port, write, addr, exp_rdata);
      if (port) begin
         DBG_Write = write; DBG_Addr = addr; DBG_WData = wdata; DBG_Req = 1'b1;
      end else begin
         CPU_Write = write; CPU_Addr = addr; CPU_WData = wdata; CPU_Req = 1'b1;
      end
      @(posedge Clock); #1;
      check("busy in issue", {31'd0, Busy}, 32'd1);
      check("write strobe", {31'd0, Mem_Write}, {31'd0, write});
      check("read strobe", {31'd0, Mem_Read}, {31'd0, ~write});
      check("mem addr", {23'd0, Mem_Addr}, {23'd0, addr});
      if (write) check("mem wdata", Mem_WData, wdata);
      @(posedge Clock); #1;
      check("ack timing", {31'd0, port ? DBG_Ack : CPU_Ack}, 32'd1);
      check("strobes off", {30'd0, Mem_Read, Mem_Write}, 32'd0);
      @(posedge Clock); #1;
      CPU_Req = 1'b0; DBG_Req = 1'b0;
      check("idle after ack", {31'd0, Busy}, 32'd0);
      if (!write) check("rdata held", port ? DBG_RData : CPU_RData, exp_rdata);
   endtask

   // Both ports issue reads, holding Req for n_cpu / n_dbg transactions each.
   task automatic run_both(input int n_cpu, input int n_dbg, input logic [AW-1:0] ca,
                           input logic [AW-1:0] da, input int budget);
      int cpu_left = n_cpu;
      int dbg_left = n_dbg;
      int cycles = 0;
      int start = ack_t.size();
      CPU_Write = 1'b0; CPU_Addr = ca; DBG_Write = 1'b0; DBG_Addr = da;
      CPU_Req = (cpu_left > 0); DBG_Req = (dbg_left > 0);
      while ((cpu_left > 0 || dbg_left > 0) && cycles < budget) begin
         @(negedge Clock);
         if (CPU_Ack) cpu_left--;
         if (DBG_Ack) dbg_left--;
         @(posedge Clock); #1;
         CPU_Req = (cpu_left > 0); DBG_Req = (dbg_left > 0);
         cycles++;
      end
      check("run_both within budget", {31'd0, cycles >= budget}, 32'd0);
      CPU_Req = 1'b0; DBG_Req = 1'b0;
      for (int i = start + 1; i < ack_t.size(); i++)
         check("ack spacing", ack_t[i] - ack_t[i-1], 32'd3);
   endtask

   typedef struct {
      logic          port;
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1'b0, 1'b1, 9'h055, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b0, 1'b0, 9'h055, 32'h0,        32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'h0};
      vecs[3] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'h12345678};
      vecs[4] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'h12345678};
      vecs[5] = '{1'b1, 1'b0, 9'h055, 32'h0,        32'hDEADBEEF};
      vecs[6] = '{1'b0, 1'b1, 9'h000, 32'hA5A5A5A5, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 9'h000, 32'h0,        32'hA5A5A5A5};
      for (int i = 0; i < 512; i++) ram[i] = '0;

      #2;
      check("reset busy", {31'd0, Busy}, 32'd0);
      check("reset strobes", {30'd0, Mem_Read, Mem_Write}, 32'd0);
      check("reset acks", {30'd0, CPU_Ack, DBG_Ack}, 32'd0);
      check("reset grant", {31'd0, Grant_DBG}, 32'd0);
      check("reset cpu rdata", CPU_RData, 32'd0);
      check("reset dbg rdata", DBG_RData, 32'd0);
      check("reset mem addr", {23'd0, Mem_Addr}, 32'd0);
      check("reset mem wdata", Mem_WData, 32'd0);
      @(posedge Clock); #1;
      Reset = 1'b0;
      @(posedge Clock); #1;

      for (int i = 0; i < 8; i++)
         run_single(vecs[i].port, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

      // Simultaneous requests: CPU wins, DBG follows three cycles later.
      push_exp(1'b0, 1'b0, 9'h055, 32'hDEADBEEF);
      push_exp(1'b1, 1'b0, 9'h1FF, 32'h12345678);
      run_both(1, 1, 9'h055, 9'h1FF, 20);

      // Request changes after acceptance must not reach the RAM.
      push_exp(1'b0, 1'b1, 9'h123, 32'h0);
      CPU_Write = 1'b1; CPU_Addr = 9'h123; CPU_WData = 32'h11112222; CPU_Req = 1'b1;
      @(posedge Clock); #1;
      CPU_Addr = 9'h0F0; CPU_WData = 32'h0;
      check("latched addr", {23'd0, Mem_Addr}, 32'h123);
      check("latched wdata", Mem_WData, 32'h11112222);
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      CPU_Req = 1'b0;
      check("ram latched write", ram[9'h123], 32'h11112222);
      check("ram untouched", ram[9'h0F0], 32'h0);

      // DBG_RData holds through a CPU write.
      run_single(1'b1, 1'b0, 9'h1FF, 32'h0, 32'h12345678);
      run_single(1'b0, 1'b1, 9'h0C3, 32'h0BADCAFE, 32'h0);
      check("dbg rdata hold", DBG_RData, 32'h12345678);

      // Reset during ISSUE of a write aborts it before the RAM edge.
      CPU_Write = 1'b1; CPU_Addr = 9'h0AA; CPU_WData = 32'hCAFEF00D; CPU_Req = 1'b1;
      @(posedge Clock); #1;
      check("pre-abort strobe", {31'd0, Mem_Write}, 32'd1);
      #2 Reset = 1'b1;
      #1;
      check("abort strobe drop", {31'd0, Mem_Write}, 32'd0);
      check("abort busy", {31'd0, Busy}, 32'd0);
      check("abort ack", {30'd0, CPU_Ack, DBG_Ack}, 32'd0);
      CPU_Req = 1'b0; CPU_Write = 1'b0;
      @(posedge Clock); #1;
      Reset = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      check("abort ram unchanged", ram[9'h0AA], 32'h0);
      check("abort cpu rdata", CPU_RData, 32'h0);
      check("abort dbg rdata", DBG_RData, 32'h0);

      // CPU holds Req for 4 reads while DBG wants 2.
`ifdef ARB_ROUND_ROBIN_EN
      push_exp(1'b0, 1'b0, 9'h055, 32'hDEADBEEF);
      push_exp(1'b1, 1'b0, 9'h000, 32'hA5A5A5A5);
      push_exp(1'b0, 1'b0, 9'h055, 32'hDEADBEEF);
      push_exp(1'b1, 1'b0, 9'h000, 32'hA5A5A5A5);
      push_exp(1'b0, 1'b0, 9'h055, 32'hDEADBEEF);
      push_exp(1'b0, 1'b0, 9'h055, 32'hDEADBEEF);
`else
      for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 9'h055, 32'hDEADBEEF);
      for (int i = 0; i < 2; i++) push_exp(1'b1, 1'b0, 9'h000, 32'hA5A5A5A5);
`endif
      run_both(4, 2, 9'h055, 9'h000, 40);

      repeat (2) @(posedge Clock);
      #1;
      check("scoreboard drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule
